// File: rtl/score_display_ctrl.sv
// Shot-counter display controller: scan strobe prescaler, serial double-dabble
// score-to-BCD converter, and a timed overlay that can take over the two low digits.
module score_display_ctrl #(
  parameter int unsigned SCAN_DIV   = 25000,
  parameter int unsigned HOLD_TICKS = 8000,
  parameter int unsigned SCORE_MAX  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] score_val,
  input  logic       score_load,
  input  logic       ovr_req,
  input  logic [3:0] ovr_d1,
  input  logic [3:0] ovr_d0,
  output logic       scan_en,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       dp3,
  output logic       dp2,
  output logic       dp1,
  output logic       dp0,
  output logic       busy,
  output logic       ovr_active
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    val_q, val_d;
  logic [7:0]    scr_q, scr_d;
  logic [2:0]    bit_q, bit_d;
  logic          pend_q, pend_d;
  logic [6:0]    pend_val_q, pend_val_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          act_q, act_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    d1_q, d1_d, d0_q, d0_d;
  logic          dp0_q, dp0_d;
  logic [6:0]    sat_val;
  logic [7:0]    adj;

  assign sat_val = (score_val > 7'(SCORE_MAX)) ? 7'(SCORE_MAX) : score_val;
  assign scan_en = (pre_q == PW'(SCAN_DIV - 1));

  always_comb begin
    pre_d = scan_en ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    adj = scr_q;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;

    state_d    = state_q;
    val_d      = val_q;
    scr_d      = scr_q;
    bit_d      = bit_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    score_d    = score_q;

    case (state_q)
      IDLE: begin
        if (score_load) begin
          val_d   = sat_val;
          scr_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, val_d} = {adj[6:0], val_q, 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd6) state_d = LOAD;
        if (score_load) begin
          pend_d     = 1'b1;
          pend_val_d = sat_val;
        end
      end
      LOAD: begin
        score_d = scr_q;
        state_d = IDLE;
        // A load arriving now counts as pending and is newer than any stored one.
        if (score_load || pend_q) begin
          val_d   = score_load ? sat_val : pend_val_q;
          scr_d   = '0;
          bit_d   = '0;
          pend_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    act_d  = act_q;
    hold_d = hold_q;
    ovr_d  = ovr_q;
    if (act_q && scan_en) begin
      if (hold_q <= HW'(1)) begin
        act_d  = 1'b0;
        hold_d = '0;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end
    // A new request overrides an expiry in the same cycle.
    if (ovr_req) begin
      ovr_d  = {ovr_d1, ovr_d0};
      act_d  = 1'b1;
      hold_d = HW'(HOLD_TICKS);
    end
  end

  always_comb begin
    d1_d  = act_q ? ovr_q[7:4] : score_q[7:4];
    d0_d  = act_q ? ovr_q[3:0] : score_q[3:0];
    dp0_d = act_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q      <= '0;
      state_q    <= IDLE;
      val_q      <= '0;
      scr_q      <= '0;
      bit_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      score_q    <= '0;
      ovr_q      <= '0;
      act_q      <= 1'b0;
      hold_q     <= '0;
      d1_q       <= '0;
      d0_q       <= '0;
      dp0_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      state_q    <= state_d;
      val_q      <= val_d;
      scr_q      <= scr_d;
      bit_q      <= bit_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      score_q    <= score_d;
      ovr_q      <= ovr_d;
      act_q      <= act_d;
      hold_q     <= hold_d;
      d1_q       <= d1_d;
      d0_q       <= d0_d;
      dp0_q      <= dp0_d;
    end
  end

  assign d3         = 4'hF;
  assign d2         = 4'hF;
  assign d1         = d1_q;
  assign d0         = d0_q;
  assign dp3        = 1'b0;
  assign dp2        = 1'b0;
  assign dp1        = 1'b0;
  assign dp0        = dp0_q;
  assign busy       = (state_q != IDLE);
  assign ovr_active = act_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a short scan period and hold.
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] score_val = '0;
  logic       score_load = 1'b0;
  logic       ovr_req = 1'b0;
  logic [3:0] ovr_d1 = '0;
  logic [3:0] ovr_d0 = '0;
  logic       scan_en, busy, ovr_active;
  logic [3:0] d3, d2, d1, d0;
  logic       dp3, dp2, dp1, dp0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  score_display_ctrl #(.SCAN_DIV(4), .HOLD_TICKS(3), .SCORE_MAX(99)) dut (
    .clk(clk), .rst(rst), .score_val(score_val), .score_load(score_load),
    .ovr_req(ovr_req), .ovr_d1(ovr_d1), .ovr_d0(ovr_d0), .scan_en(scan_en),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp3(dp3), .dp2(dp2), .dp1(dp1), .dp0(dp0),
    .busy(busy), .ovr_active(ovr_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [6:0] v, input logic [7:0] exp, input logic [7:0] prev);
    score_val  = v;
    score_load = 1'b1;
    step(1);
    score_load = 1'b0;
    check("busy_start", 16'(busy), 16'd1);
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check("busy_run", 16'(busy), 16'd1);
    end
    step(1);
    check("busy_done", 16'(busy), 16'd0);
    check("disp_hold", 16'({d1, d0}), 16'(prev));
    step(1);
    check("disp_new", 16'({d1, d0}), 16'(exp));
  endtask

  task automatic hold_ticks(input logic [7:0] dig, output int unsigned n);
    n = 0;
    for (int i = 0; i < 64 && ovr_active; i++) begin
      if (scan_en) n++;
      step(1);
      if (i == 0) check("ovr_disp", 16'({dp0, d1, d0}), 16'({1'b1, dig}));
    end
    check("ovr_drop", 16'(ovr_active), 16'd0);
  endtask

  initial begin
    int unsigned pos[3];
    int unsigned npulse;
    int unsigned n;
    int unsigned busy_low;
    logic seen35;

    // Reset state
    step(3);
    check("rst_digits", {d3, d2, d1, d0}, 16'hFF00);
    check("rst_flags", 16'({scan_en, busy, ovr_active, dp3, dp2, dp1, dp0}), 16'd0);

    // Free-running scan strobe: one-cycle pulses every 4 cycles
    rst = 1'b1;
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (scan_en && npulse < 3) begin
        pos[npulse] = k;
        npulse++;
      end
    end
    check("scan_count", 16'(npulse), 16'd3);
    check("scan_gap0", 16'(pos[1] - pos[0]), 16'd4);
    check("scan_gap1", 16'(pos[2] - pos[1]), 16'd4);
    check("idle_digits", {d3, d2, d1, d0}, 16'hFF00);
    check("idle_busy", 16'(busy), 16'd0);

    // Plain conversions, including saturation
    convert(7'd47, 8'h47, 8'h00);
    convert(7'd120, 8'h99, 8'h47);

    // Loads while busy: last one wins, intermediate value never shown
    score_val  = 7'd12;
    score_load = 1'b1;
    step(1);
    score_load = 1'b0;
    step(1);
    score_val  = 7'd35;
    score_load = 1'b1;
    step(1);
    score_load = 1'b0;
    step(1);
    score_val  = 7'd58;
    score_load = 1'b1;
    step(1);
    score_load = 1'b0;
    busy_low = 0;
    seen35   = 1'b0;
    for (int k = 5; k <= 17; k++) begin
      step(1);
      if ({d1, d0} == 8'h35) seen35 = 1'b1;
      if (k <= 15 && !busy) busy_low++;
      if (k == 8) check("pend_pre", 16'({d1, d0}), 16'h0099);
      if (k == 9) check("pend_first", 16'({d1, d0}), 16'h0012);
      if (k == 16) begin
        check("pend_mid", 16'({d1, d0}), 16'h0012);
        check("pend_idle", 16'(busy), 16'd0);
      end
      if (k == 17) check("pend_last", 16'({d1, d0}), 16'h0058);
    end
    check("pend_skip", 16'(seen35), 16'd0);
    check("pend_busy", 16'(busy_low), 16'd0);

    // Overlay for three scan ticks, then score restored
    ovr_d1  = 4'hA;
    ovr_d0  = 4'h3;
    ovr_req = 1'b1;
    step(1);
    ovr_req = 1'b0;
    check("ovr_act", 16'(ovr_active), 16'd1);
    check("ovr_lag", 16'({dp0, d1, d0}), 16'h0058);
    hold_ticks(8'hA3, n);
    check("ovr_ticks", 16'(n), 16'd3);
    step(1);
    check("ovr_restore", 16'({dp0, d1, d0}), 16'h0058);

    // Second request mid-hold restarts the full hold and relatches digits
    ovr_req = 1'b1;
    step(1);
    ovr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && n == 0; i++) begin
      if (scan_en) n++;
      else step(1);
    end
    check("ovr_first_tick", 16'(n), 16'd1);
    ovr_d1  = 4'h2;
    ovr_d0  = 4'h7;
    ovr_req = 1'b1;
    step(1);
    ovr_req = 1'b0;
    check("ovr_still", 16'(ovr_active), 16'd1);
    hold_ticks(8'h27, n);
    check("ovr_extend", 16'(n), 16'd3);
    step(1);
    check("ovr_restore2", 16'({dp0, d1, d0}), 16'h0058);

    // Reset during a conversion and an overlay
    score_val  = 7'd77;
    score_load = 1'b1;
    step(1);
    score_load = 1'b0;
    step(2);
    ovr_d1  = 4'h1;
    ovr_d0  = 4'h1;
    ovr_req = 1'b1;
    step(1);
    ovr_req = 1'b0;
    check("mid_state", 16'({busy, ovr_active}), 16'd3);
    rst = 1'b0;
    step(1);
    check("rst2_digits", {d3, d2, d1, d0}, 16'hFF00);
    check("rst2_flags", 16'({scan_en, busy, ovr_active, dp3, dp2, dp1, dp0}), 16'd0);
    rst = 1'b1;
    convert(7'd5, 8'h05, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Controller that sequences the 4-digit seven-segment multiplexer for the shot-counter display. Generates the ~4 kHz scan_en strobe and converts the binary score to BCD with an iterative 7-cycle double-dabble engine. Arbitrates the two low digits between the score path and a timed overlay requester (e.g. shot-result code). Outputs feed the mux digit/dp inputs directly.

Parameters:
SCAN_DIV, 25000, clk cycles per scan_en pulse (100 MHz / 4 kHz); legal range >= 2
HOLD_TICKS, 8000, scan_en pulses an overlay stays on the display (~2 s)
SCORE_MAX, 99, saturation ceiling for the displayed score

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
score_val  in  7  binary score, sampled on score_load
score_load  in  1  one-cycle request to convert and display score_val
ovr_req  in  1  one-cycle overlay request
ovr_d1  in  4  overlay tens digit (BCD, or 4'hA-4'hF = blank)
ovr_d0  in  4  overlay ones digit
scan_en  out  1  one-cycle scan strobe to the mux
d3, d2, d1, d0  out  4 each  digit data to the mux
dp3, dp2, dp1, dp0  out  1 each  decimal-point requests to the mux
busy  out  1  conversion in progress
ovr_active  out  1  overlay currently owns d1/d0

Behaviour:
- Reset (rst==0 at posedge): prescaler=0, scan_en=0, FSM=IDLE, pending=0, score BCD=00, d1=d0=0, d3=d2=4'hF, all dp=0, busy=0, ovr_active=0, hold counter=0. rst has priority over every other input.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. scan_en=1 for exactly the cycle where count==SCAN_DIV-1. Period SCAN_DIV cycles and free-running, independent of all other activity.
- Saturation: captured value = min(score_val, SCORE_MAX).
- Conversion FSM states: IDLE, SHIFT, LOAD.
  - IDLE: score_load=1 -> capture value, clear the 8-bit BCD scratch, bit count=0, go to SHIFT. busy=1 from the next cycle.
  - SHIFT: one double-dabble iteration per cycle. For each BCD nibble >=5, add 3, then shift left bringing in the next value MSB. 7 iterations, then go to LOAD.
  - LOAD: copy scratch to the score BCD registers. Go to IDLE, or to SHIFT if pending=1 (capture the pending value, clear pending).
  - busy=1 in SHIFT and LOAD.
- Latency: score_load sampled at edge N -> new score on d1/d0 after edge N+9 (1 capture + 7 shift + 1 load), if no overlay is active.
- score_load while busy: store the value in the pending register and set pending=1. Last write wins; there is no queue deeper than 1. A load in the same cycle the FSM goes LOAD->IDLE is treated as pending.
- Overlay: on ovr_req=1, latch ovr_d1/ovr_d0, set ovr_active=1, and set hold counter=HOLD_TICKS. The counter decrements on each scan_en while active. When it reaches 0 with a scan_en pending, ovr_active=0 on the following edge. ovr_req while active relatches the digits and restarts the hold.
- Simultaneous ovr_req and a hold expiry: ovr_req wins (stays active, counter reloaded).
- Output select (registered, one cycle after the source changes): d1/d0 = overlay digits if ovr_active, else score BCD. d3=d2=4'hF always. dp0=ovr_active, dp1=dp2=dp3=0.
- Score conversions continue in the background during an overlay. The updated score appears the cycle after the overlay ends.

Test Plan:
- Release rst, run 60000 cycles -> scan_en pulses at cycles 25000 and 50000 after release, each 1 cycle wide; d1=d0=0, d3=d2=4'hF, busy=0.
- score_val=47, score_load at edge N -> busy high N+1..N+8; d1=4, d0=7 after N+9. Repeat with score_val=120 -> d1=9, d0=9.
- score_val=12 loaded, then score_val=35 and 58 loaded at N+2 and N+4 -> display goes 12 then 58; 35 is never shown; busy stays high continuously until 58 is loaded.
- ovr_req with ovr_d1=4'hA, ovr_d0=3 (HOLD_TICKS=3, SCAN_DIV=4 in bench) -> d1=4'hA, d0=3, dp0=1 for 3 scan ticks, then the score is restored and dp0=0. A second ovr_req mid-hold extends the hold by the full 3 ticks.
- Assert rst=0 mid-conversion and mid-overlay -> next edge all outputs at reset values; post-release conversion of 5 gives d1=0, d0=5.
